// File: rtl/bank_requester.sv
// Initiator side of the memory bank port: buffers core requests in a FIFO, issues them one at a
// time to the bank, and returns exactly one in-order response per request, with a read timeout.
module bank_requester #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_data,
  output logic              bank_read_enable,
  output logic              bank_write_enable,
  input  logic [DATA_W-1:0] bank_data_out,
  input  logic              bank_valid_out,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t             state, state_next;
  req_t               mem [FIFO_DEPTH];
  req_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [TMR_W-1:0]   timer;
  logic               full, empty, push, pop, timed_out;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  // ISSUE is only entered with a non-empty FIFO, so it doubles as the pop strobe.
  assign pop       = (state == S_ISSUE);
  assign head      = mem[rd_ptr];
  assign timed_out = (timer == TMR_W'(TIMEOUT));
  assign busy      = (state != S_IDLE) || !empty;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only read after being written, and the pointers
  // and count (which are reset) define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_ISSUE;
      S_ISSUE: state_next = head.we ? S_RESP : S_WAIT;
      S_WAIT:  if (bank_valid_out || timed_out) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = empty ? S_IDLE : S_ISSUE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid         = 1'b0;
    bank_addr         = '0;
    bank_data         = '0;
    bank_read_enable  = 1'b0;
    bank_write_enable = 1'b0;
    case (state)
      S_ISSUE: begin
        bank_addr         = head.addr;
        bank_data         = head.wdata;
        bank_read_enable  = !head.we;
        bank_write_enable = head.we;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Timer reads 1 in the first WAIT cycle; the response registers only change when
  // a response is being formed, so they hold steady through a RESP stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_next == S_WAIT) timer <= (state == S_WAIT) ? timer + TMR_W'(1) : TMR_W'(1);
      else                      timer <= '0;
      if (state == S_ISSUE && head.we) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else if (state == S_WAIT) begin
        if (bank_valid_out) begin
          rdata_q <= bank_data_out;
          err_q   <= 1'b0;
        end else if (timed_out) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_requester.sv
// Scoreboard bench for bank_requester: directed requests push expected responses into a queue,
// a monitor pops and compares on each response handshake; a bank model answers after a set delay.
module tb_bank_requester;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] bank_addr, bank_data, bank_data_out;
  logic       bank_read_enable, bank_write_enable, bank_valid_out;
  logic       busy;

  bank_requester #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bank_addr(bank_addr), .bank_data(bank_data),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_data_out(bank_data_out), .bank_valid_out(bank_valid_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bank model: registered memory; valid_out rises bank_delay cycles after read_enable
  // is sampled (0 = never answers).
  logic [7:0] bmem [256];
  int         bank_delay;
  int         left = 0;
  logic       pend = 1'b0;

  initial begin
    bank_valid_out = 1'b0;
    bank_data_out  = 8'h00;
  end

  always @(posedge clk) begin
    bank_valid_out <= 1'b0;
    if (bank_write_enable) bmem[bank_addr] <= bank_data;
    if (bank_read_enable) begin
      bank_data_out <= bmem[bank_addr];
      if (bank_delay == 1) bank_valid_out <= 1'b1;
      else if (bank_delay > 1) begin
        pend <= 1'b1;
        left <= bank_delay - 1;
      end
    end else if (pend) begin
      if (left == 1) begin
        bank_valid_out <= 1'b1;
        pend <= 1'b0;
      end
      left <= left - 1;
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Protocol watcher: enable overlap, non-zero bank bus outside ISSUE, response stability.
  logic       stalled = 1'b0;
  logic [7:0] s_rdata;
  logic       s_err;

  always @(negedge clk) begin
    if (bank_read_enable || bank_write_enable) en_cnt++;
    if (bank_read_enable && bank_write_enable) viol++;
    if (!bank_read_enable && !bank_write_enable && (bank_addr != 0 || bank_data != 0)) viol++;
    if (reset !== 1'b1) stalled = 1'b0;
    else begin
      if (stalled && (!rsp_valid || rsp_rdata !== s_rdata || rsp_err !== s_err)) viol++;
      stalled = rsp_valid && !rsp_ready;
      s_rdata = rsp_rdata;
      s_err   = rsp_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request and returns #1 after the accepting edge; lat < 0 = no cycle check.
  task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic track, input logic [7:0] erd, input logic eerr, input int lat);
    int budget = 0;
    int ec;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("push_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ec = (lat < 0) ? -1 : cyc + lat;
    if (track) sb.push_back('{rdata: erd, err: eerr, cyc: ec});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      tick(1);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int e0, v0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    rsp_ready = 1'b1;
    bank_delay = 1;

    // Reset held three cycles, then idle.
    tick(3);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_bank_addr", 32'(bank_addr), 32'd0);
    check("rst_bank_data", 32'(bank_data), 32'd0);
    check("rst_bank_re", 32'(bank_read_enable), 32'd0);
    check("rst_bank_we", 32'(bank_write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    e0 = en_cnt;
    tick(5);
    check("idle_no_enable", en_cnt - e0, 0);

    // Single write then single read, with exact latency.
    push(1'b1, 8'd9, 8'd24, 1'b1, 8'd0, 1'b0, 2);
    wait_drain();
    push(1'b0, 8'd9, 8'd0, 1'b1, 8'd24, 1'b0, 3);
    wait_drain();

    // Back-to-back mix, responses in order.
    v0 = viol;
    push(1'b1, 8'd255, 8'd145, 1'b1, 8'd0, 1'b0, -1);
    push(1'b1, 8'd9, 8'd98, 1'b1, 8'd0, 1'b0, -1);
    push(1'b0, 8'd255, 8'd0, 1'b1, 8'd145, 1'b0, -1);
    push(1'b0, 8'd9, 8'd0, 1'b1, 8'd98, 1'b0, -1);
    wait_drain();
    check("b2b_protocol", viol - v0, 0);

    // Response back-pressure fills the FIFO.
    rsp_ready = 1'b0;
    push(1'b1, 8'd1, 8'd11, 1'b1, 8'd0, 1'b0, -1);
    push(1'b0, 8'd1, 8'd0, 1'b1, 8'd11, 1'b0, -1);
    push(1'b1, 8'd2, 8'd22, 1'b1, 8'd0, 1'b0, -1);
    push(1'b0, 8'd2, 8'd0, 1'b1, 8'd22, 1'b0, -1);
    push(1'b0, 8'd255, 8'd0, 1'b1, 8'd145, 1'b0, -1);
    check("full_req_ready", 32'(req_ready), 32'd0);
    tick(8);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    check("stall_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    wait_drain();

    // Timeout: never, exactly on the timeout cycle, one cycle too late.
    bank_delay = 0;
    push(1'b0, 8'd9, 8'd0, 1'b1, 8'd0, 1'b1, 2 + TIMEOUT);
    wait_drain();
    bank_delay = TIMEOUT;
    push(1'b0, 8'd9, 8'd0, 1'b1, 8'd98, 1'b0, 2 + TIMEOUT);
    wait_drain();
    bank_delay = TIMEOUT + 1;
    push(1'b0, 8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 2 + TIMEOUT);
    wait_drain();
    tick(3);

    // Reset while waiting on a read with two entries queued.
    bank_delay = 0;
    push(1'b0, 8'd2, 8'd0, 1'b0, 8'd0, 1'b0, -1);
    push(1'b1, 8'd3, 8'd33, 1'b0, 8'd0, 1'b0, -1);
    push(1'b0, 8'd1, 8'd0, 1'b0, 8'd0, 1'b0, -1);
    tick(4);
    check("wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_re", 32'(bank_read_enable), 32'd0);
    check("mid_rst_we", 32'(bank_write_enable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(2);
    reset = 1'b1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    e0 = en_cnt;
    tick(30);
    check("post_rst_no_enable", en_cnt - e0, 0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("protocol_total", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
